// File: rtl/instr_prefetch_buffer.sv
// Instruction-fetch front end: owns the PC, reads a 1-cycle-latency instruction memory,
// queues returned instructions in a small FIFO and redirects the PC on jump instructions.
module instr_prefetch_buffer #(
    parameter int         DEPTH       = 4,
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [1:0] JUMP_OPCODE = 2'b11
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_rd_en,
    output logic [7:0]               imem_addr,
    input  logic [7:0]               imem_rdata,
    output logic [7:0]               out_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       pc;
    logic             inflight;
    logic [7:0]       inflight_addr;
    logic             squash;

    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic             push_now;
    logic             pop_now;
    logic             is_jump;
    logic [CNT_W:0]   demand;
    logic [7:0]       ret_next;
    logic [7:0]       jump_target;

    // A returning read is counted twice in the room check, which keeps one slot of slack
    // so the FIFO can never overflow even while a read is outstanding.
    always_comb begin
        push_now    = inflight && !squash;
        pop_now     = out_valid && out_ready;
        is_jump     = push_now && (imem_rdata[7:6] == JUMP_OPCODE);
        ret_next    = inflight_addr + 8'd1;
        jump_target = {ret_next[7:6], imem_rdata[5:0]};
        demand      = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight) + (CNT_W+1)'(push_now);
        imem_rd_en  = !reset && (demand < (CNT_W+1)'(DEPTH));
    end

    assign imem_addr = pc;
    assign out_valid = (fifo_count != '0);
    assign out_instr = fifo_mem[rd_ptr];

    // A jump redirects the PC; the read issued alongside it fetched the wrong address,
    // so it is flagged and its data dropped when it returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            squash        <= 1'b0;
        end else begin
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                inflight_addr <= pc;
            end
            if (is_jump) begin
                pc <= jump_target;
            end else if (imem_rd_en) begin
                pc <= pc + 8'd1;
            end
            if (is_jump && imem_rd_en) begin
                squash <= 1'b1;
            end else if (inflight && squash) begin
                squash <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_now) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_now) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_now, pop_now})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_now) begin
            fifo_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: a program-order model fills a scoreboard queue,
// and a negedge monitor pops and compares every instruction the DUT hands downstream.
module tb_instr_prefetch_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_rd_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [7:0] out_instr;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;

    logic       reset_b;
    logic       imem_rd_en_b;
    logic [7:0] imem_addr_b;
    logic [7:0] imem_rdata_b;
    logic [7:0] out_instr_b;
    logic       out_valid_b;
    logic       out_ready_b;
    logic [2:0] fifo_count_b;

    logic [7:0] imem   [256];
    logic [7:0] imem_b [256];
    logic [7:0] exp_q [$];
    logic [7:0] addr_log_b [$];
    logic [7:0] out_log_b [$];

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic seen_40 = 1'b0;
    logic found;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(8'h00), .JUMP_OPCODE(2'b11)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_instr  (out_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count)
    );

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(8'hFE), .JUMP_OPCODE(2'b11)) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .imem_rd_en (imem_rd_en_b),
        .imem_addr  (imem_addr_b),
        .imem_rdata (imem_rdata_b),
        .out_instr  (out_instr_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .fifo_count (fifo_count_b)
    );

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= imem[imem_addr];
        if (imem_rd_en_b) imem_rdata_b <= imem_b[imem_addr_b];
    end

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    // Walks the program in fetch order, following jumps the way the front end should.
    task automatic apply_stimulus(input logic [7:0] start_pc, input int n);
        logic [7:0] a;
        logic [7:0] v;
        logic [7:0] nxt;
        a = start_pc;
        for (int i = 0; i < n; i++) begin
            v = imem[a];
            exp_q.push_back(v);
            nxt = a + 8'd1;
            if (v[7:6] == 2'b11) a = {nxt[7:6], v[5:0]};
            else a = nxt;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_output("count_le_depth", {7'b0, (fifo_count <= 3'(DEPTH))}, 8'd1);
            if (out_valid && out_ready) begin
                if (out_instr == 8'h40) seen_40 = 1'b1;
                if (exp_q.size() == 0) begin
                    check_output("unexpected_output", out_instr, 8'hxx);
                end else begin
                    check_output("stream", out_instr, exp_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_b) begin
            if (imem_rd_en_b && addr_log_b.size() < 4) addr_log_b.push_back(imem_addr_b);
            if (out_valid_b && out_log_b.size() < 4) out_log_b.push_back(out_instr_b);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i]   = 8'(i);
            imem_b[i] = {2'b00, 6'(i)};
        end
        imem[8'h3F] = 8'hC5;

        reset       = 1'b1;
        reset_b     = 1'b1;
        out_ready   = 1'b1;
        out_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_rd_en", {7'b0, imem_rd_en}, 8'd0);
        check_output("rst_valid", {7'b0, out_valid}, 8'd0);
        check_output("rst_count", {5'b0, fifo_count}, 8'd0);

        // Basic in-order fetch and first-instruction latency.
        apply_stimulus(8'h00, 80);
        mon_en = 1'b1;
        reset  = 1'b0;
        #1;
        check_output("first_rd_en", {7'b0, imem_rd_en}, 8'd1);
        check_output("first_addr", imem_addr, 8'h00);
        @(negedge clk);
        check_output("lat_n1_valid", {7'b0, out_valid}, 8'd0);
        @(negedge clk);
        check_output("lat_n2_valid", {7'b0, out_valid}, 8'd1);
        check_output("lat_n2_instr", out_instr, 8'h00);
        @(posedge clk);
        #1 reset_b = 1'b0;

        // Backpressure: FIFO saturates, fetching stops, stream stays continuous afterwards.
        repeat (15) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_output("bp_count", {5'b0, fifo_count}, 8'd4);
        check_output("bp_rd_en", {7'b0, imem_rd_en}, 8'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;

        check_output("b_addr_log_size", 8'(addr_log_b.size()), 8'd4);
        check_output("b_out_log_size", 8'(out_log_b.size()), 8'd4);
        if (addr_log_b.size() == 4 && out_log_b.size() == 4) begin
            check_output("b_addr0", addr_log_b[0], 8'hFE);
            check_output("b_addr1", addr_log_b[1], 8'hFF);
            check_output("b_addr2", addr_log_b[2], 8'h00);
            check_output("b_addr3", addr_log_b[3], 8'h01);
            check_output("b_out0", out_log_b[0], 8'h3E);
            check_output("b_out1", out_log_b[1], 8'h3F);
            check_output("b_out2", out_log_b[2], 8'h00);
            check_output("b_out3", out_log_b[3], 8'h01);
        end

        // Drain through the jump at 3F; its squashed successor must never appear.
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        check_output("drain1_empty", 8'(exp_q.size()), 8'd0);
        check_output("no_40_first", {7'b0, seen_40}, 8'd0);

        // Reset while the FIFO holds three entries and a read is outstanding.
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (fifo_count == 3'd3 && imem_rd_en) found = 1'b1;
        end
        check_output("found_3_inflight", {7'b0, found}, 8'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_output("pre_rst_count", {5'b0, fifo_count}, 8'd3);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_output("rst2_valid", {7'b0, out_valid}, 8'd0);
        check_output("rst2_count", {5'b0, fifo_count}, 8'd0);

        // Random downstream stalls with simultaneous push/pop; stream must restart at 00.
        apply_stimulus(8'h00, 120);
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        check_output("drain2_empty", 8'(exp_q.size()), 8'd0);
        check_output("no_40_final", {7'b0, seen_40}, 8'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
